// File: rtl/key_event_queue.sv
// Debounces NKEYS raw keys, exports the levels, and queues press / auto-repeat
// events as key codes behind a show-ahead FIFO with a valid/ready handshake.
module key_event_queue #(
  parameter int               NKEYS        = 5,
  parameter int               CODE_W       = 3,
  parameter int               DEBOUNCE     = 250000,
  parameter int               CNT_W        = 18,
  parameter logic [NKEYS-1:0] REPEAT_MASK  = 5'b11110,
  parameter int               REPEAT_DELAY = 200000,
  parameter int               REPEAT_RATE  = 50000,
  parameter int               FIFO_DEPTH   = 4,
  parameter int               PTR_W        = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NKEYS-1:0]  keyin,
  output logic [NKEYS-1:0]  keyout,
  output logic              ev_valid,
  output logic [CODE_W-1:0] ev_code,
  input  logic              ev_ready,
  output logic [PTR_W:0]    ev_count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [NKEYS-1:0]  sync_a;
  logic [NKEYS-1:0]  sync_b;
  logic [CNT_W-1:0]  db [NKEYS];
  logic [CNT_W-1:0]  rp [NKEYS];
  logic [NKEYS-1:0]  phase;
  logic [NKEYS-1:0]  pend;
  logic [NKEYS-1:0]  rise;
  logic [NKEYS-1:0]  fall;
  logic [NKEYS-1:0]  rep_fire;
  logic [NKEYS-1:0]  req;
  logic [NKEYS-1:0]  drop;
  logic [NKEYS-1:0]  grant;
  logic [NKEYS-1:0]  lowest;
  logic [CODE_W-1:0] grant_code;
  logic              found;
  logic              push;
  logic              pop;
  logic              push_ok;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= keyin;
      sync_b <= sync_a;
    end
  end

  // Accept a level change only after DEBOUNCE consecutive differing samples.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if ((sync_b[i] != keyout[i]) && (db[i] == DB_LAST)) begin
        rise[i] = sync_b[i];
        fall[i] = ~sync_b[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      keyout <= '0;
      for (int i = 0; i < NKEYS; i++) db[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (sync_b[i] == keyout[i]) begin
          db[i] <= '0;
        end else if (db[i] == DB_LAST) begin
          keyout[i] <= sync_b[i];
          db[i]     <= '0;
        end else begin
          db[i] <= db[i] + CNT_W'(1);
        end
      end
    end
  end

  // A release on this edge takes priority over a repeat that would coincide.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NKEYS; i++) begin
      rep_fire[i] = REPEAT_MASK[i] && keyout[i] && !fall[i] &&
                    (rp[i] == (phase[i] ? RATE_LAST : DELAY_LAST));
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase <= '0;
      for (int i = 0; i < NKEYS; i++) rp[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (!REPEAT_MASK[i] || !keyout[i] || fall[i]) begin
          rp[i]    <= '0;
          phase[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rp[i]    <= '0;
          phase[i] <= 1'b1;
        end else begin
          rp[i] <= rp[i] + CNT_W'(1);
        end
      end
    end
  end

  assign req  = rise | rep_fire;
  assign drop = req & pend;

  always_comb begin
    lowest     = '0;
    grant_code = '0;
    found      = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (pend[i] && !found) begin
        found      = 1'b1;
        lowest[i]  = 1'b1;
        grant_code = CODE_W'(i);
      end
    end
  end

  // A full FIFO still accepts a push when the head is being popped this cycle.
  assign pop     = ev_valid && ev_ready;
  assign push_ok = (ev_count != FULL_COUNT) || pop;
  assign push    = found && push_ok;
  assign grant   = push ? lowest : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | (req & ~pend);
      if (|drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   ev_count <= ev_count + (PTR_W+1)'(1);
        2'b01:   ev_count <= ev_count - (PTR_W+1)'(1);
        default: ev_count <= ev_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= grant_code;
  end

  assign ev_valid = (ev_count != '0);
  assign ev_code  = ev_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: short debounce/repeat limits, only key 1
// auto-repeats, expected values worked out by hand per clock edge.
module tb_key_event_queue;

  logic       clk;
  logic       rst_n;
  logic [4:0] keyin;
  logic [4:0] keyout;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       ev_ready;
  logic [2:0] ev_count;
  logic       overflow;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  key_event_queue #(
    .NKEYS(5), .CODE_W(3), .DEBOUNCE(4), .CNT_W(8), .REPEAT_MASK(5'b00010),
    .REPEAT_DELAY(8), .REPEAT_RATE(4), .FIFO_DEPTH(4), .PTR_W(2)
  ) dut (
    .CLK(clk), .RST(rst_n), .keyin(keyin), .keyout(keyout),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
    .ev_count(ev_count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [4:0] keys, input logic ready, input logic clr);
    keyin    = keys;
    ev_ready = ready;
    clr_ovf  = clr;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(5'b00000, 1'b0, 1'b0);
    tick(2);
    check_output("rst_keyout", 32'(keyout), 0);
    check_output("rst_valid", 32'(ev_valid), 0);
    check_output("rst_code", 32'(ev_code), 0);
    check_output("rst_count", 32'(ev_count), 0);
    check_output("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    tick(2);

    // Single press of key 2 held 20 cycles, consumer always ready.
    apply_stimulus(5'b00100, 1'b1, 1'b0);
    tick(5);
    check_output("t1_keyout_early", 32'(keyout), 0);
    tick(1);
    check_output("t1_keyout_rise", 32'(keyout), 32'h04);
    check_output("t1_valid_pend", 32'(ev_valid), 0);
    tick(1);
    check_output("t1_valid", 32'(ev_valid), 1);
    check_output("t1_code", 32'(ev_code), 2);
    check_output("t1_count", 32'(ev_count), 1);
    tick(1);
    check_output("t1_valid_popped", 32'(ev_valid), 0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_output("t1_no_repeat", 32'(ev_valid), 0);
    end
    apply_stimulus(5'b00000, 1'b1, 1'b0);
    tick(5);
    check_output("t1_keyout_hold", 32'(keyout), 32'h04);
    tick(1);
    check_output("t1_keyout_fall", 32'(keyout), 0);
    tick(2);
    check_output("t1_no_release_ev", 32'(ev_valid), 0);

    // Key 0 chattering every 2 cycles never settles long enough.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus((i % 2 == 0) ? 5'b00001 : 5'b00000, 1'b1, 1'b0);
      tick(2);
      check_output("t2_keyout", 32'(keyout), 0);
      check_output("t2_valid", 32'(ev_valid), 0);
    end
    tick(8);
    check_output("t2_keyout_end", 32'(keyout), 0);
    check_output("t2_valid_end", 32'(ev_valid), 0);

    // Keys 4, 1, 3 debounce together; the arbiter queues them lowest first.
    apply_stimulus(5'b11010, 1'b0, 1'b0);
    tick(6);
    check_output("t3_keyout", 32'(keyout), 32'h1a);
    tick(1);
    check_output("t3_count1", 32'(ev_count), 1);
    check_output("t3_code_first", 32'(ev_code), 1);
    tick(2);
    check_output("t3_count3", 32'(ev_count), 3);
    check_output("t3_code_head", 32'(ev_code), 1);
    apply_stimulus(5'b11010, 1'b1, 1'b0);
    tick(1);
    check_output("t3_code_second", 32'(ev_code), 3);
    check_output("t3_count2", 32'(ev_count), 2);
    tick(1);
    check_output("t3_code_third", 32'(ev_code), 4);
    tick(1);
    check_output("t3_empty", 32'(ev_valid), 0);
    apply_stimulus(5'b11010, 1'b0, 1'b0);
    tick(2);
    check_output("t3_before_repeat", 32'(ev_count), 0);
    tick(1);
    check_output("t3_first_repeat", 32'(ev_count), 1);
    check_output("t3_repeat_code", 32'(ev_code), 1);
    tick(3);
    check_output("t3_rate_wait", 32'(ev_count), 1);
    tick(1);
    check_output("t3_second_repeat", 32'(ev_count), 2);
    apply_stimulus(5'b00000, 1'b1, 1'b0);
    tick(10);
    check_output("t3_drained", 32'(ev_count), 0);
    check_output("t3_released", 32'(keyout), 0);

    // Keys 1 and 2 with ready low: queue 1,2,1,1 fills, then key 1 overflows.
    apply_stimulus(5'b00110, 1'b0, 1'b0);
    tick(19);
    check_output("t4_full", 32'(ev_count), 4);
    check_output("t4_head", 32'(ev_code), 1);
    tick(6);
    check_output("t4_pend_waits", 32'(overflow), 0);
    check_output("t4_count_sat", 32'(ev_count), 4);
    tick(1);
    check_output("t4_ovf_set", 32'(overflow), 1);
    apply_stimulus(5'b00110, 1'b0, 1'b1);
    tick(1);
    check_output("t4_ovf_clr", 32'(overflow), 0);
    apply_stimulus(5'b00110, 1'b1, 1'b0);
    tick(1);
    check_output("t5_count_full_pp", 32'(ev_count), 4);
    check_output("t5_head_advance", 32'(ev_code), 2);
    apply_stimulus(5'b00110, 1'b0, 1'b0);
    tick(2);
    check_output("t4_new_pend_ok", 32'(overflow), 0);
    tick(4);
    check_output("t4_ovf_again", 32'(overflow), 1);
    apply_stimulus(5'b00110, 1'b0, 1'b1);
    tick(1);
    check_output("t4_clr_again", 32'(overflow), 0);
    tick(2);
    check_output("t4_clr_held", 32'(overflow), 0);
    tick(1);
    check_output("t4_set_beats_clr", 32'(overflow), 1);
    apply_stimulus(5'b00000, 1'b1, 1'b1);
    tick(15);
    check_output("t4_drain_count", 32'(ev_count), 0);
    check_output("t4_drain_ovf", 32'(overflow), 0);

    // Reset with three events queued and key 0 mid-debounce.
    apply_stimulus(5'b11100, 1'b0, 1'b0);
    tick(9);
    check_output("t6_three_queued", 32'(ev_count), 3);
    check_output("t6_head", 32'(ev_code), 2);
    apply_stimulus(5'b11101, 1'b0, 1'b0);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_keyout", 32'(keyout), 0);
    check_output("t6_rst_valid", 32'(ev_valid), 0);
    check_output("t6_rst_code", 32'(ev_code), 0);
    check_output("t6_rst_count", 32'(ev_count), 0);
    check_output("t6_rst_ovf", 32'(overflow), 0);
    apply_stimulus(5'b00001, 1'b0, 1'b0);
    tick(3);
    check_output("t6_in_reset", 32'(ev_count), 0);
    rst_n = 1'b1;
    tick(6);
    check_output("t6_keyout_back", 32'(keyout), 1);
    check_output("t6_no_stale", 32'(ev_valid), 0);
    tick(1);
    check_output("t6_event", 32'(ev_valid), 1);
    check_output("t6_event_code", 32'(ev_code), 0);
    tick(5);
    check_output("t6_single_event", 32'(ev_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
# key_event_queue

Parametrised successor to the current five-key chattering remover feeding `display`. It synchronises and debounces `NKEYS` raw key inputs, exports debounced levels (drop-in for today's `keyout`), and converts key presses, plus optional auto-repeat while held, into a queue of key-code events with a valid/ready handshake. Game logic can then consume exactly one move per event instead of edge-detecting levels itself.

## Interface
- `NKEYS`, 5: number of key channels.
- `CODE_W`, 3: event code width; must satisfy 2^CODE_W >= NKEYS.
- `DEBOUNCE`, 250000: consecutive stable cycles required before a level change is accepted; minimum 1.
- `CNT_W`, 18: debounce and repeat counter width; must hold `DEBOUNCE`, `REPEAT_DELAY` and `REPEAT_RATE`.
- `REPEAT_MASK`, 5'b11110: per-key auto-repeat enable; bit i applies to key i.
- `REPEAT_DELAY`, 200000: cycles from a press event to the first repeat event.
- `REPEAT_RATE`, 50000: cycles between subsequent repeat events.
- `FIFO_DEPTH`, 4: event queue depth; power of two, minimum 2.
- `PTR_W`, 2: log2(`FIFO_DEPTH`).
- `CLK` input 1: system clock; the only clock.
- `RST` input 1: asynchronous, active-low reset.
- `keyin` input `NKEYS`: raw key levels, asynchronous, active-high.
- `keyout` output `NKEYS`: debounced key levels.
- `ev_valid` output 1: queue non-empty; `ev_code` is valid.
- `ev_code` output `CODE_W`: key index of the oldest queued event.
- `ev_ready` input 1: consumer accepts the event.
- `ev_count` output `PTR_W+1`: number of queued events, 0..`FIFO_DEPTH`.
- `overflow` output 1: sticky flag; an event was dropped.
- `clr_ovf` input 1: synchronous clear of `overflow`.

## Operation
- **Reset values.** While `RST`=0, all state clears asynchronously: synchronisers, counters, `keyout`, pending bits, FIFO pointers and `overflow`. Outputs are `keyout`=0, `ev_valid`=0, `ev_code`=0, `ev_count`=0 and `overflow`=0. Queued and pending events are discarded.
- **Synchroniser.** Two flops per key. `s[i]` is the second-stage output.
- **Debounce.** Per-key counter `db[i]`.
  - If `s[i]`==`keyout[i]`, `db[i]` is set to 0.
  - Otherwise `db[i]` increments.
  - When `db[i]`==`DEBOUNCE`-1 and `s[i]` still differs, the same edge sets `keyout[i]`<=`s[i]` and `db[i]`<=0.
- **Press event.** On the edge where `keyout[i]` goes 0->1, a request for key i is raised. Releases never raise a request.
- **Auto-repeat.** Applies only when `REPEAT_MASK[i]`=1.
  - A per-key counter `rp[i]` loads 0 on the press edge and counts while `keyout[i]`=1.
  - A first request is raised when `rp[i]` reaches `REPEAT_DELAY`-1, and `rp[i]` is then reloaded to 0.
  - Later requests are raised each time `rp[i]` reaches `REPEAT_RATE`-1.
  - A phase flag selects which limit applies; it clears on release.
  - When `keyout[i]` goes to 0, `rp[i]` is set to 0.
- **Pending bits.** A request sets `pend[i]`. If `pend[i]` is already 1 when a new request for key i arrives, the new request is dropped and `overflow` is set.
- **Arbiter.** Each cycle, the lowest-index set `pend` bit is pushed into the FIFO if a push is allowed, and that bit clears. At most one push per cycle.
- **FIFO.** Show-ahead.
  - `ev_valid`=(`ev_count`!=0), and `ev_code` is the head entry.
  - A pop occurs when `ev_valid`&&`ev_ready`.
  - A push is allowed when `ev_count`<`FIFO_DEPTH`, or when the FIFO is full and a pop occurs in the same cycle; in that case `ev_count` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - When the FIFO is full and no pop occurs, pending bits wait; nothing is lost until a second request for the same key arrives.
- **Overflow flag.** `clr_ovf` clears `overflow`. If a set and `clr_ovf` occur in the same cycle, the set wins.
- **Consumer side.** `ev_ready` while empty has no effect.

## Timing
- `keyin[i]` rising and held stable, first sampled at edge 0:
  - `s[i]`=1 after edge 2.
  - `keyout[i]`=1 after edge 2+`DEBOUNCE`.
  - `pend[i]`=1 after that same edge.
  - Push, with `ev_valid`=1, one edge later (empty FIFO, no lower-index pending bit).
- A glitch shorter than `DEBOUNCE` cycles at `s[i]` leaves `keyout` unchanged.
- The first repeat request comes `REPEAT_DELAY` cycles after the press request; later requests are every `REPEAT_RATE` cycles.
- Pop takes effect at the edge where `ev_valid`&&`ev_ready`. The next entry appears on `ev_code` after that edge; there are no bubbles.
- `ev_count` is registered and reflects all pushes and pops of the previous edge.

## Test plan
- **Single press and release.** `DEBOUNCE`=4, key 2 held high for 20 cycles, `ev_ready`=1.
  - `keyout[2]` rises 6 cycles after `keyin` rises.
  - Exactly one event, code 2, with `ev_valid` high for 1 cycle.
  - `keyout[2]` falls 6 cycles after release, with no event.
- **Chatter rejection.** Key 0 toggles every 2 cycles for 30 cycles with `DEBOUNCE`=4 -> `keyout`=0 throughout, no events.
- **Simultaneous press and arbitration.** Keys 4, 1 and 3 cross debounce on the same edge, `ev_ready`=0 -> queue holds codes 1, 3, 4 in that order, `ev_count`=3.
- **Full queue and overflow.** `FIFO_DEPTH`=4, `ev_ready`=0, repeat on key 1 with `REPEAT_DELAY`=8 and `REPEAT_RATE`=4.
  - `ev_count` saturates at 4 and `pend[1]` holds.
  - The next request sets `overflow`=1.
  - `clr_ovf` clears it.
  - Popping one event admits the pending event.
- **Push/pop when full.** Hold 4 events, pend 1 more, pulse `ev_ready` for 1 cycle -> `ev_count` stays 4 and the head advances.
- **Reset mid-operation.** Drop `RST` low with 3 events queued and a key mid-debounce -> all outputs 0 immediately. After release, no stale events appear, and a key held through reset produces one event 2+`DEBOUNCE`+1 cycles later.
